// File: rtl/bin_to_bcd_display.sv
// Sequential shift-add-3 binary-to-BCD converter feeding a seven-segment driver.
// Build option BCD_SATURATE_EN: overflow inputs convert as MAX_VAL instead of an error pattern.
module bin_to_bcd_display #(
  parameter int BIN_W   = 14,
  parameter int DIGITS  = 4,
  parameter int MAX_VAL = 9999
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int                BCD_W      = 4 * DIGITS;
  localparam int                CNT_W      = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0]  LAST_SHIFT = CNT_W'(BIN_W - 1);
  localparam logic [31:0]       MAX_U      = 32'(MAX_VAL);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [BIN_W-1:0]   shift_reg;
  logic [BCD_W-1:0]   bcd_acc;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_result;
  logic [CNT_W-1:0]   bit_cnt;
  logic [BIN_W-1:0]   load_val;
  logic               ovf_lat;
  logic               in_ovf;
  logic               accept;
  logic               shift_en;
  logic               finish;

  // Compare in 32 bits so a MAX_VAL beyond the input range simply never overflows.
  assign in_ovf = (32'(bin) > MAX_U);

`ifdef BCD_SATURATE_EN
  localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);
  assign load_val   = in_ovf ? MAX_BIN : bin;
  assign bcd_result = bcd_acc;
`else
  localparam logic [BCD_W-1:0] ERR_PATTERN = {DIGITS{4'hE}};
  assign load_val   = bin;
  assign bcd_result = ovf_lat ? ERR_PATTERN : bcd_acc;
`endif

  // State register
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  // NOTE: assign a default before the case so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == LAST_SHIFT) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy     = (state != IDLE);
    accept   = (state == IDLE) && start;
    shift_en = (state == SHIFT);
    finish   = (state == FINISH);
  end

  // Add 3 to each nibble >= 5 before the shift; nibbles are < 10 so no carry out.
  always_comb begin
    bcd_adj = bcd_acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_acc[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_acc[4*d +: 4] + 4'd3;
    end
  end

  // Conversion datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bcd_acc   <= '0;
      bit_cnt   <= '0;
      ovf_lat   <= 1'b0;
    end else if (accept) begin
      shift_reg <= load_val;
      bcd_acc   <= '0;
      bit_cnt   <= '0;
      ovf_lat   <= in_ovf;
    end else if (shift_en) begin
      {bcd_acc, shift_reg} <= {bcd_adj[BCD_W-2:0], shift_reg, 1'b0};
      bit_cnt              <= bit_cnt + 1'b1;
    end
  end

  // Result registers only move on the FINISH edge, so bcd never shows a partial value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd  <= '0;
      ovf  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= finish;
      if (finish) begin
        bcd <= bcd_result;
        ovf <= ovf_lat;
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Self-checking bench for bin_to_bcd_display: directed cases plus random values against
// an arithmetic decimal-digit model. Define BCD_SATURATE_EN to match a saturating build.
module tb_bin_to_bcd_display;

  localparam int BIN_W   = 14;
  localparam int DIGITS  = 4;
  localparam int MAX_VAL = 9999;
  localparam int LAT     = BIN_W + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [BIN_W-1:0]  bin = '0;
  logic              busy, done, ovf;
  logic [15:0]       bcd;

  int n_cmp = 0;
  int n_bad = 0;

  bin_to_bcd_display #(.BIN_W(BIN_W), .DIGITS(DIGITS), .MAX_VAL(MAX_VAL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal digits by division; overflow gives the error or saturated pattern.
  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    int          x;
    r = '0;
    x = v;
    if (v > MAX_VAL) begin
`ifdef BCD_SATURATE_EN
      x = MAX_VAL;
`else
      return 16'hEEEE;
`endif
    end
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Counts negedges until done is seen high (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (done !== 1'b1 && lat < 200);
  endtask

  // Full conversion: accept on the next edge, scramble bin while busy, check timing and result.
  task automatic convert(input int v, input string tag);
    int lat;
    @(negedge clk);
    start = 1'b1;
    bin   = BIN_W'(v);
    @(negedge clk);
    start = 1'b0;
    bin   = BIN_W'($urandom);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(lat);
    check({tag, "_lat"}, 32'(lat), 32'(LAT));
    check({tag, "_bcd"}, 32'(bcd), 32'(ref_bcd(v)));
    check({tag, "_ovf"}, 32'(ovf), (v > MAX_VAL) ? 32'd1 : 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int          lat, gap, v;
    bit          saw_done, stable;
    logic [15:0] held;

    // Reset state, before any clock edge
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd",  32'(bcd),  32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed values including both sides of the overflow boundary
    convert(1234,  "c1234");
    convert(0,     "c0");
    convert(9999,  "c9999");
    convert(12000, "c12000");
    convert(10000, "c10000");
    convert(16383, "cmax");
    convert(7,     "c7");

    // Start while busy is ignored; start in the done cycle is accepted
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd1234;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    bin   = 14'd42;
    @(negedge clk);
    start = 1'b0;
    lat = 5;
    do begin
      @(negedge clk);
      lat++;
    end while (done !== 1'b1 && lat < 200);
    check("ign_lat", 32'(lat), 32'(LAT));
    check("ign_bcd", 32'(bcd), 32'h1234);
    start = 1'b1;
    bin   = 14'd42;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done(lat);
    check("b2b_lat", 32'(lat), 32'(LAT));
    check("b2b_bcd", 32'(bcd), 32'h0042);

    // Asynchronous reset in the middle of a conversion
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd5678;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_bcd",  32'(bcd),  32'd0);
    check("arst_ovf",  32'(ovf),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    stable   = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
      if (bcd !== 16'h0000) stable = 1'b0;
    end
    check("arst_no_done", 32'(saw_done), 32'd0);
    check("arst_bcd_zero", 32'(stable), 32'd1);

    // Start held high: accept lands in each done cycle, so pulses are LAT+1 edges apart
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd321;
    @(negedge clk);
    wait_done(lat);
    check("hold_first_lat", 32'(lat), 32'(LAT));
    check("hold_first_bcd", 32'(bcd), 32'h0321);
    for (int p = 0; p < 3; p++) begin
      gap    = 0;
      stable = 1'b1;
      do begin
        @(negedge clk);
        gap++;
        if (bcd !== 16'h0321) stable = 1'b0;
      end while (done !== 1'b1 && gap < 200);
      check("hold_gap", 32'(gap), 32'(LAT + 1));
      check("hold_stable", 32'(stable), 32'd1);
    end
    start = 1'b0;
    @(negedge clk);
    wait_done(lat);
    @(negedge clk);

    // Random values, biased so some land above MAX_VAL
    for (int i = 0; i < 20; i++) begin
      v = (i % 4 == 3) ? int'($urandom_range(MAX_VAL + 1, (1 << BIN_W) - 1))
                       : int'($urandom_range(0, MAX_VAL));
      held = ref_bcd(v);
      convert(v, "rand");
      check("rand_hold", 32'(bcd), 32'(held));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
